// File: rtl/maxnet_pkg.sv
// Shared types and constants for the Maxnet job sequencer and its job FIFO.
package maxnet_pkg;

    localparam int FP_W        = 32;
    localparam int TAG_W       = 4;
    localparam int TIMEOUT_DEF = 1024;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [FP_W-1:0]  eps;
        logic [FP_W-1:0]  a1;
        logic [FP_W-1:0]  a2;
        logic [FP_W-1:0]  a3;
        logic [FP_W-1:0]  a4;
        logic [TAG_W-1:0] tag;
    } job_t;

endpackage

// File: rtl/maxnet_job_fifo.sv
// Small job queue: operands plus tag, show-ahead head, simultaneous push/pop allowed when full.
module maxnet_job_fifo
    import maxnet_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  job_t din,
    input  logic pop,
    output job_t dout,
    output logic empty,
    output logic full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    job_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (!do_push && do_pop) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/maxnet_sequencer.sv
// Queues jobs, launches one Maxnet run at a time, and returns tagged results in issue order.
module maxnet_sequencer
    import maxnet_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [FP_W-1:0]  job_eps,
    input  logic [FP_W-1:0]  job_a1,
    input  logic [FP_W-1:0]  job_a2,
    input  logic [FP_W-1:0]  job_a3,
    input  logic [FP_W-1:0]  job_a4,
    output logic             mx_start,
    output logic [FP_W-1:0]  mx_eps,
    output logic [FP_W-1:0]  mx_a1,
    output logic [FP_W-1:0]  mx_a2,
    output logic [FP_W-1:0]  mx_a3,
    output logic [FP_W-1:0]  mx_a4,
    input  logic             mx_finish,
    input  logic [FP_W-1:0]  mx_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [FP_W-1:0]  res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             err,
    output logic             busy
);

    localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t            state_reg;
    state_t            state_next;
    job_t              fifo_din;
    job_t              fifo_head;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              capture;
    logic              timeout;
    logic              fin_reg;
    logic [WC_W-1:0]   wait_cnt_reg;
    logic [TAG_W-1:0]  tag_cnt_reg;
    logic [TAG_W-1:0]  cur_tag_reg;

    assign job_ready = !fifo_full;
    assign push      = job_valid && job_ready;
    assign fifo_din  = '{eps: job_eps, a1: job_a1, a2: job_a2, a3: job_a3, a4: job_a4,
                         tag: tag_cnt_reg};
    assign busy      = (state_reg != ST_IDLE) || !fifo_empty;

    maxnet_job_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        capture    = 1'b0;
        timeout    = 1'b0;
        mx_start   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // Hold off issuing while a result is still waiting to be drained.
                if (!fifo_empty && !res_valid) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                mx_start   = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // Only a fresh 0->1 transition counts; a stale high level is ignored.
                if (mx_finish && !fin_reg) begin
                    capture    = 1'b1;
                    state_next = ST_DONE;
                end else if (wait_cnt_reg == WC_W'(TIMEOUT - 1)) begin
                    timeout    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fin_reg      <= 1'b0;
            wait_cnt_reg <= '0;
            tag_cnt_reg  <= '0;
            cur_tag_reg  <= '0;
            mx_eps       <= '0;
            mx_a1        <= '0;
            mx_a2        <= '0;
            mx_a3        <= '0;
            mx_a4        <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_tag      <= '0;
            err          <= 1'b0;
        end else begin
            fin_reg      <= mx_finish;
            wait_cnt_reg <= (state_reg == ST_WAIT) ? wait_cnt_reg + 1'b1 : '0;
            if (push) begin
                tag_cnt_reg <= tag_cnt_reg + 1'b1;
            end
            if (pop) begin
                mx_eps      <= fifo_head.eps;
                mx_a1       <= fifo_head.a1;
                mx_a2       <= fifo_head.a2;
                mx_a3       <= fifo_head.a3;
                mx_a4       <= fifo_head.a4;
                cur_tag_reg <= fifo_head.tag;
            end
            if (capture) begin
                res_valid <= 1'b1;
                res_data  <= mx_out;
                res_tag   <= cur_tag_reg;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
            if (timeout) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_maxnet_sequencer.sv
// Scoreboard bench for maxnet_sequencer with a behavioural Maxnet that returns the FP max of a1..a4.
module tb_maxnet_sequencer;

    typedef struct {
        logic [31:0] eps;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] a3;
        logic [31:0] a4;
        logic [3:0]  tag;
    } job_s;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
    } res_s;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [31:0] job_eps = '0, job_a1 = '0, job_a2 = '0, job_a3 = '0, job_a4 = '0;
    logic        mx_start;
    logic [31:0] mx_eps, mx_a1, mx_a2, mx_a3, mx_a4;
    logic        mx_finish;
    logic [31:0] mx_out;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] res_data;
    logic [3:0]  res_tag;
    logic        err;
    logic        busy;

    int          n_vec = 0;
    int          n_err = 0;
    job_s        iss_q[$];
    res_s        res_q[$];
    logic [3:0]  tag_model = '0;

    int          fin_delay = 0;
    int          fin_hi = 1;
    int          m_cnt = -1;
    int          hi_left = 0;
    logic [31:0] m_res;
    logic        prev_start;
    job_s        mj;

    always #5 clk = ~clk;

    maxnet_sequencer #(
        .DEPTH   (2),
        .TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .job_valid (job_valid),
        .job_ready (job_ready),
        .job_eps   (job_eps),
        .job_a1    (job_a1),
        .job_a2    (job_a2),
        .job_a3    (job_a3),
        .job_a4    (job_a4),
        .mx_start  (mx_start),
        .mx_eps    (mx_eps),
        .mx_a1     (mx_a1),
        .mx_a2     (mx_a2),
        .mx_a3     (mx_a3),
        .mx_a4     (mx_a4),
        .mx_finish (mx_finish),
        .mx_out    (mx_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_tag   (res_tag),
        .err       (err),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Ordering key for IEEE-754 singles so that an unsigned compare gives numeric order.
    function automatic logic [31:0] fkey(input logic [31:0] x);
        return x[31] ? ~x : {1'b1, x[30:0]};
    endfunction

    function automatic logic [31:0] fmax4(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
        logic [31:0] m;
        m = a;
        if (fkey(b) > fkey(m)) m = b;
        if (fkey(c) > fkey(m)) m = c;
        if (fkey(d) > fkey(m)) m = d;
        return m;
    endfunction

    task automatic send_job(input logic [31:0] e, input logic [31:0] a1, input logic [31:0] a2,
                            input logic [31:0] a3, input logic [31:0] a4, input bit expect_res);
        job_s j;
        res_s r;
        int   g;
        g = 0;
        job_valid = 1'b1;
        job_eps = e; job_a1 = a1; job_a2 = a2; job_a3 = a3; job_a4 = a4;
        while (!job_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("job_accept", 32'(job_ready), 32'd1);
        j = '{e, a1, a2, a3, a4, tag_model};
        iss_q.push_back(j);
        if (expect_res) begin
            r.data = fmax4(a1, a2, a3, a4);
            r.tag  = tag_model;
            res_q.push_back(r);
        end
        $display("job  tag=%0d eps=%08h a=%08h %08h %08h %08h", tag_model, e, a1, a2, a3, a4);
        tag_model = tag_model + 4'd1;
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic wait_for_start(input string tag);
        int g;
        g = 0;
        while (!mx_start && g < 100) begin
            @(negedge clk);
            g++;
        end
        check(tag, 32'(mx_start), 32'd1);
    endtask

    task automatic wait_for_valid(input string tag);
        int g;
        g = 0;
        while (!res_valid && g < 100) begin
            @(negedge clk);
            g++;
        end
        check(tag, 32'(res_valid), 32'd1);
    endtask

    task automatic drain(input string tag);
        int g;
        g = 0;
        while (res_q.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        check(tag, 32'(res_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        iss_q.delete();
        res_q.delete();
        tag_model = '0;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
    endtask

    // Maxnet model: answers each mx_start after fin_delay cycles (negative: never).
    initial begin
        mx_finish = 1'b0;
        mx_out = '0;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_cnt = -1;
                hi_left = 0;
                mx_finish = 1'b0;
                prev_start = 1'b0;
            end else begin
                if (hi_left > 0) begin
                    hi_left--;
                    if (hi_left == 0) mx_finish = 1'b0;
                end
                if (m_cnt > 0) begin
                    m_cnt--;
                end else if (m_cnt == 0) begin
                    if (mx_finish) begin
                        mx_finish = 1'b0;
                        hi_left = 0;
                    end else begin
                        check("op_hold_eps", mx_eps, mj.eps);
                        check("op_hold_a4", mx_a4, mj.a4);
                        mx_out = m_res;
                        mx_finish = 1'b1;
                        hi_left = fin_hi;
                        m_cnt = -1;
                    end
                end
                if (mx_start) begin
                    check("start_pulse", 32'(prev_start), 32'd0);
                    if (iss_q.size() == 0) begin
                        check("unexpected_start", 32'(mx_start), 32'd0);
                    end else begin
                        mj = iss_q.pop_front();
                        check("mx_eps", mx_eps, mj.eps);
                        check("mx_a1", mx_a1, mj.a1);
                        check("mx_a2", mx_a2, mj.a2);
                        check("mx_a3", mx_a3, mj.a3);
                        check("mx_a4", mx_a4, mj.a4);
                        m_res = fmax4(mx_a1, mx_a2, mx_a3, mx_a4);
                        m_cnt = fin_delay;
                    end
                end
                prev_start = mx_start;
            end
        end
    end

    // Result monitor: pops the scoreboard on each handshake and checks hold stability.
    initial begin
        logic        hold;
        logic [31:0] hd;
        logic [3:0]  ht;
        res_s        r;
        hold = 1'b0;
        hd = '0;
        ht = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_valid", 32'(res_valid), 32'd1);
                    check("hold_data", res_data, hd);
                    check("hold_tag", 32'(res_tag), 32'(ht));
                end
                if (res_valid && res_ready) begin
                    $display("res  tag=%0d data=%08h", res_tag, res_data);
                    if (res_q.size() == 0) begin
                        check("unexpected_res", 32'(res_valid), 32'd0);
                    end else begin
                        r = res_q.pop_front();
                        check("res_data", res_data, r.data);
                        check("res_tag", 32'(res_tag), 32'(r.tag));
                    end
                end
                hold = res_valid && !res_ready;
                hd = res_data;
                ht = res_tag;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   starts;
        logic anyv;

        #1 rst = 1'b0;
        #2;
        check("rst_job_ready", 32'(job_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_mx_start", 32'(mx_start), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);

        // Single job: exact start and result latencies.
        fin_delay = 0;
        fin_hi = 1;
        send_job(32'hBE4CCCCD, 32'h42FD6666, 32'hC0A00000, 32'h00000000, 32'hBE4CCCCD, 1'b1);
        check("s1_start_lat1", 32'(mx_start), 32'd0);
        @(negedge clk);
        check("s1_start_lat2", 32'(mx_start), 32'd1);
        check("s1_mx_a1", mx_a1, 32'h42FD6666);
        @(negedge clk);
        check("s1_res_lat1", 32'(res_valid), 32'd0);
        @(negedge clk);
        check("s1_res_lat2", 32'(res_valid), 32'd1);
        check("s1_res_data", res_data, 32'h42FD6666);
        check("s1_res_tag", 32'(res_tag), 32'd0);
        drain("s1_drain");

        // Three back-to-back jobs with a slow Maxnet and a stalled result sink.
        do_reset();
        fin_delay = 10;
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_job($urandom, $urandom, $urandom, $urandom, $urandom, 1'b1);
        end
        check("s2_ready_full", 32'(job_ready), 32'd0);
        check("s2_busy", 32'(busy), 32'd1);
        wait_for_valid("s2_first_valid");
        starts = 0;
        repeat (20) begin
            @(negedge clk);
            starts += int'(mx_start);
        end
        check("s3_no_start", 32'(starts), 32'd0);
        check("s3_valid_held", 32'(res_valid), 32'd1);
        @(posedge clk);
        #1 res_ready = 1'b1;
        drain("s2_drain");

        // Leftover high mx_finish must not complete the next job.
        fin_delay = 1;
        fin_hi = 1000;
        send_job(32'h3C23D70A, 32'h3F800000, 32'h40000000, 32'hC0400000, 32'h3F000000, 1'b1);
        drain("s4_drain_a");
        fin_delay = 6;
        fin_hi = 1;
        send_job(32'h3C23D70A, 32'hC1200000, 32'hC0000000, 32'hBF800000, 32'hC2C80000, 1'b1);
        wait_for_start("s4_start_b");
        repeat (6) begin
            @(negedge clk);
            check("s4_no_level", 32'(res_valid), 32'd0);
        end
        drain("s4_drain_b");

        // Timeout: err exactly 16 cycles into WAIT, then the queued job runs.
        fin_delay = -1;
        send_job(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555, 1'b0);
        send_job(32'h3F000000, 32'h40400000, 32'hC0400000, 32'h40A00000, 32'h3F800000, 1'b1);
        wait_for_start("s5_start_t");
        repeat (16) @(negedge clk);
        check("s5_err_early", 32'(err), 32'd0);
        @(negedge clk);
        check("s5_err_set", 32'(err), 32'd1);
        check("s5_no_res", 32'(res_valid), 32'd0);
        fin_delay = 2;
        drain("s5_drain");
        check("s5_err_sticky", 32'(err), 32'd1);

        // Asynchronous reset in the middle of WAIT.
        fin_delay = -1;
        send_job(32'hDEADBEEF, 32'h40490FDB, 32'hC0490FDB, 32'h3F800000, 32'h00000001, 1'b0);
        wait_for_start("s6_start");
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("s6_mx_start", 32'(mx_start), 32'd0);
        check("s6_res_valid", 32'(res_valid), 32'd0);
        check("s6_res_data", res_data, 32'd0);
        check("s6_res_tag", 32'(res_tag), 32'd0);
        check("s6_mx_eps", mx_eps, 32'd0);
        check("s6_mx_a1", mx_a1, 32'd0);
        check("s6_mx_a2", mx_a2, 32'd0);
        check("s6_mx_a3", mx_a3, 32'd0);
        check("s6_mx_a4", mx_a4, 32'd0);
        check("s6_err", 32'(err), 32'd0);
        check("s6_busy", 32'(busy), 32'd0);
        check("s6_job_ready", 32'(job_ready), 32'd1);
        iss_q.delete();
        res_q.delete();
        tag_model = '0;
        @(negedge clk);
        #2 rst = 1'b1;
        fin_delay = 1;
        anyv = 1'b0;
        repeat (30) begin
            @(negedge clk);
            anyv = anyv | res_valid;
        end
        check("s6_no_result", 32'(anyv), 32'd0);
        check("s6_idle", 32'(busy), 32'd0);
        send_job(32'h3F800000, 32'h3E800000, 32'h3F400000, 32'hBF400000, 32'h3F000000, 1'b1);
        drain("s6_post_drain");

        check("final_iss_q", 32'(iss_q.size()), 32'd0);
        check("final_res_q", 32'(res_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
